// File: rtl/jtag_tap_responder.sv
// ---------------------------------------------------------------------------
// jtag_tap_responder
// Device-side JTAG TAP. It oversamples tck/tms/tdi on clk, so every part of
// the TAP runs in the clk domain. The TAP has a 4-bit IR and three data
// registers: IDCODE, BYPASS, and a 32-bit USER register with capture and
// update ports.
//
// Optional feature macro: JTAG_TAP_TRST_EN. Defining it adds a trst input
// (active high, synchronised). trst resets the TAP only. The USER update
// port keeps its value.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   tck, tms, tdi      JTAG pins (asynchronous to clk)
//   tdo, tdo_en        JTAG data out and its enable (high while shifting)
//   user_capture_data  value loaded into USER DR at Capture-DR
//   user_update_data   USER DR value latched at Update-DR
//   user_update_valid  one-clk pulse when user_update_data is written
//   ir_value           current instruction register
//   trst               (JTAG_TAP_TRST_EN only) TAP reset, active high
// ---------------------------------------------------------------------------
module jtag_tap_responder #(
    parameter logic [31:0]  IDCODE      = 32'h10001FFF,
    parameter logic [3:0]   IR_IDCODE   = 4'h1,
    parameter logic [3:0]   IR_USER     = 4'h8,
    parameter int unsigned  SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef JTAG_TAP_TRST_EN
    input  logic        trst,
`endif
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        tdo_en,
    input  logic [31:0] user_capture_data,
    output logic [31:0] user_update_data,
    output logic        user_update_valid,
    output logic [3:0]  ir_value
);

    localparam int unsigned DR_W = 32;
    localparam int unsigned IR_W = 4;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_prev;
    logic [IR_W-1:0]        ir_shift;
    logic [DR_W-1:0]        idcode_shift;
    logic [DR_W-1:0]        user_shift;
    logic                   bypass_shift;

    // The synchroniser's last stage gives the coherent tck/tms/tdi samples.
    logic tck_s, tms_s, tdi_s, rise_c, fall_c, tap_reset_c;
    logic sel_idcode_c, sel_user_c, dr_lsb_c;

    assign tck_s  = tck_sync[SYNC_STAGES-1];
    assign tms_s  = tms_sync[SYNC_STAGES-1];
    assign tdi_s  = tdi_sync[SYNC_STAGES-1];
    assign rise_c = tck_s & ~tck_prev;
    assign fall_c = ~tck_s & tck_prev;

    assign sel_idcode_c = (ir_value == IR_IDCODE);
    assign sel_user_c   = (ir_value == IR_USER);
    assign dr_lsb_c     = sel_idcode_c ? idcode_shift[0] :
                          sel_user_c   ? user_shift[0]   : bypass_shift;

`ifdef JTAG_TAP_TRST_EN
    logic [SYNC_STAGES-1:0] trst_sync;
    always_ff @(posedge clk) begin
        if (rst) trst_sync <= '0;
        else     trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst};
    end
    assign tap_reset_c = trst_sync[SYNC_STAGES-1];
`else
    assign tap_reset_c = 1'b0;
`endif

    // IEEE 1149.1 state graph
    function automatic state_t next_state(input state_t s, input logic m);
        case (s)
            TLR:     next_state = m ? TLR    : RTI;
            RTI:     next_state = m ? SEL_DR : RTI;
            SEL_DR:  next_state = m ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = m ? EX1_DR : SH_DR;
            SH_DR:   next_state = m ? EX1_DR : SH_DR;
            EX1_DR:  next_state = m ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = m ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = m ? UPD_DR : SH_DR;
            UPD_DR:  next_state = m ? SEL_DR : RTI;
            SEL_IR:  next_state = m ? TLR    : CAP_IR;
            CAP_IR:  next_state = m ? EX1_IR : SH_IR;
            SH_IR:   next_state = m ? EX1_IR : SH_IR;
            EX1_IR:  next_state = m ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = m ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = m ? UPD_IR : SH_IR;
            UPD_IR:  next_state = m ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    endfunction

    // TAP state machine, shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync          <= '0;
            tms_sync          <= '0;
            tdi_sync          <= '0;
            tck_prev          <= 1'b0;
            state             <= TLR;
            ir_value          <= IR_IDCODE;
            ir_shift          <= '0;
            idcode_shift      <= '0;
            user_shift        <= '0;
            bypass_shift      <= 1'b0;
            tdo               <= 1'b0;
            tdo_en            <= 1'b0;
            user_update_data  <= '0;
            user_update_valid <= 1'b0;
        end else begin
            tck_sync          <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync          <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync          <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_prev          <= tck_s;
            user_update_valid <= 1'b0;

            if (tap_reset_c) begin
                state    <= TLR;
                ir_value <= IR_IDCODE;
                tdo      <= 1'b0;
                tdo_en   <= 1'b0;
            end else if (rise_c) begin
                // Current state's action first, then advance on tms
                case (state)
                    TLR:    ir_value <= IR_IDCODE;
                    CAP_IR: ir_shift <= IR_W'(1);
                    SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_W-1:1]};
                    UPD_IR: ir_value <= ir_shift;
                    CAP_DR: begin
                        if (sel_idcode_c)    idcode_shift <= IDCODE;
                        else if (sel_user_c) user_shift   <= user_capture_data;
                        else                 bypass_shift <= 1'b0;
                    end
                    SH_DR: begin
                        if (sel_idcode_c)    idcode_shift <= {tdi_s, idcode_shift[DR_W-1:1]};
                        else if (sel_user_c) user_shift   <= {tdi_s, user_shift[DR_W-1:1]};
                        else                 bypass_shift <= tdi_s;
                    end
                    UPD_DR: begin
                        if (sel_user_c) begin
                            user_update_data  <= user_shift;
                            user_update_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                state <= next_state(state, tms_s);
            end else if (fall_c) begin
                // tdo changes only on falling tck so the host samples it stable
                if (state == SH_DR) begin
                    tdo    <= dr_lsb_c;
                    tdo_en <= 1'b1;
                end else if (state == SH_IR) begin
                    tdo    <= ir_shift[0];
                    tdo_en <= 1'b1;
                end else begin
                    tdo    <= 1'b0;
                    tdo_en <= 1'b0;
                end
            end
        end
    end

endmodule
